// File: rtl/trace_capture_pkg.sv
// Shared encodings for the trace capture block: trigger modes, FSM states and
// the trigger compare used on qualified sample cycles.
package trace_capture_pkg;

  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_PC   = 2'd1;
  localparam logic [1:0] TRIG_MASK = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Mode 3 is reserved and never fires.
  function automatic logic trig_match(input logic [1:0]  mode,
                                      input logic [31:0] value,
                                      input logic [31:0] mask,
                                      input logic [31:0] pc,
                                      input logic [31:0] instr);
    logic hit;
    case (mode)
      TRIG_IMM:  hit = 1'b1;
      TRIG_PC:   hit = (pc == value);
      TRIG_MASK: hit = ((instr & mask) == (value & mask));
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/trace_capture_ram.sv
// Sample storage: one write port clocked on the rising edge, one
// combinational read port. Contents are deliberately not reset.
module trace_ram #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store a sample on a qualified write.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trace_capture.sv
// On-chip logic analyser: captures probe channels into a ring buffer around a
// trigger, then streams the captured window oldest-first over valid/ready.
module trace_capture
  import trace_capture_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   stop,
  input  logic [1:0]             trig_mode,
  input  logic [31:0]            trig_value,
  input  logic [31:0]            trig_mask,
  input  logic [PTR_W-1:0]       post_count,
  input  logic                   sample_en,
  input  logic [31:0]            probe_pc,
  input  logic [31:0]            probe_instr,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  output logic [1:0]             state,
  output logic                   triggered,
  output logic [PTR_W:0]         count,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [N_CH*DATA_W-1:0] rd_data,
  output logic                   rd_last
);

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  state_t           state_q, state_d;
  logic             triggered_q, triggered_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] post_q, post_d;
  logic [PTR_W:0]   remain_q, remain_d;
  logic             wr_en;
  logic             go_done;

  trace_ram #(
    .WIDTH (N_CH * DATA_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wptr_q),
    .wr_data (ch_data),
    .rd_addr (rptr_q),
    .rd_data (rd_data)
  );

  assign state     = state_q;
  assign triggered = triggered_q;
  assign count     = count_q;
  assign rd_valid  = (state_q == ST_DONE);
  assign rd_last   = rd_valid && (remain_q == (PTR_W + 1)'(1));

  // Next-state logic: capture, trigger/post countdown, and read-out handshake.
  always_comb begin
    state_d     = state_q;
    triggered_d = triggered_q;
    count_d     = count_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    post_d      = post_q;
    remain_d    = remain_q;
    wr_en       = 1'b0;
    go_done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d     = ST_ARMED;
          count_d     = '0;
          wptr_d      = '0;
          triggered_d = 1'b0;
        end
      end
      ST_ARMED, ST_POST: begin
        if (sample_en) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + PTR_W'(1);
          if (count_q != FULL) begin
            count_d = count_q + (PTR_W + 1)'(1);
          end
          if (state_q == ST_ARMED) begin
            if (trig_match(trig_mode, trig_value, trig_mask, probe_pc, probe_instr)) begin
              triggered_d = 1'b1;
              if (post_count == '0) begin
                go_done = 1'b1;
              end else begin
                post_d  = post_count;
                state_d = ST_POST;
              end
            end
          end else begin
            post_d = post_q - PTR_W'(1);
            if (post_q == PTR_W'(1)) begin
              go_done = 1'b1;
            end
          end
        end
        if (stop) begin
          go_done = 1'b1;
        end
      end
      ST_DONE: begin
        if (arm) begin
          state_d     = ST_ARMED;
          count_d     = '0;
          wptr_d      = '0;
          triggered_d = 1'b0;
        end else if (rd_ready) begin
          rptr_d   = rptr_q + PTR_W'(1);
          remain_d = remain_q - (PTR_W + 1)'(1);
          if (remain_q == (PTR_W + 1)'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Window start is computed from the post-write pointer and count so a
    // sample stored on the final cycle is included.
    if (go_done) begin
      if (count_d == '0) begin
        state_d = ST_IDLE;
      end else begin
        state_d  = ST_DONE;
        rptr_d   = wptr_d - count_d[PTR_W-1:0];
        remain_d = count_d;
      end
    end
  end

  // State and pointer registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      triggered_q <= 1'b0;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      post_q      <= '0;
      remain_q    <= '0;
    end else begin
      state_q     <= state_d;
      triggered_q <= triggered_d;
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      post_q      <= post_d;
      remain_q    <= remain_d;
    end
  end

endmodule
